// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative shift-add multiplier:
//   state_t     - controller states (IDLE / BUSY / DONE)
//   calc_cnt_w  - width of a counter that must hold values 0..width
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Smallest r with 2**r >= width+1, i.e. $clog2(width+1).
   function automatic int calc_cnt_w(input int width);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < (width + 1)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_addsub_step.sv
// -----------------------------------------------------------------------------
// mult_addsub_step
// Combinational add/subtract stage of one radix-2 shift-add iteration.
// Produces the next (WIDTH+1)-bit upper accumulator half, before the shift.
// Ports:
//   i_upper       current upper half (one guard bit + WIDTH bits)
//   i_m           multiplicand
//   i_signed_mode 1 = two's-complement operands
//   i_last_iter   high on iteration WIDTH-1
//   i_lsb         accumulator LSB (current multiplier bit)
//   o_upper_nxt   upper half after the conditional add/subtract
// -----------------------------------------------------------------------------
module mult_addsub_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   i_upper,
   input  logic [WIDTH-1:0] i_m,
   input  logic             i_signed_mode,
   input  logic             i_last_iter,
   input  logic             i_lsb,
   output logic [WIDTH:0]   o_upper_nxt
);

   logic [WIDTH:0] w_m_ext;

   // Guard bit carries the sign of m in signed mode so the sum cannot overflow.
   assign w_m_ext = {i_signed_mode & i_m[WIDTH-1], i_m};

   always_comb begin
      o_upper_nxt = i_upper;
      if (i_lsb) begin
         // The multiplier MSB has negative weight in two's complement.
         if (i_signed_mode && i_last_iter) o_upper_nxt = i_upper - w_m_ext;
         else                              o_upper_nxt = i_upper + w_m_ext;
      end
   end

endmodule

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
// Iterative radix-2 shift-add multiplier, signed or unsigned operands.
// Operands accepted via in_valid/in_ready, product returned via
// out_valid/out_ready. WIDTH iterations, then one cycle to register p.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      operands valid          in_ready   ready for operands (IDLE)
//   m, q          multiplicand, multiplier
//   signed_mode   1 = two's complement, sampled with the operands
//   out_valid     product valid (DONE)    out_ready  consumer accepts product
//   p             2*WIDTH-bit product, held throughout DONE
//   busy          high in BUSY or DONE
// -----------------------------------------------------------------------------
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = calc_cnt_w(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   m,
   input  logic [WIDTH-1:0]   q,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int AW = 2 * WIDTH + 1;

   state_t               r_state;
   logic [WIDTH-1:0]     r_m;
   logic                 r_signed;
   logic [AW-1:0]        r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_p;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic [WIDTH:0]       w_upper_nxt;
   logic                 w_last_iter;
   logic                 w_shift_in;

   assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
   // Arithmetic shift replicates the guard bit; logical shift inserts zero.
   assign w_shift_in  = r_signed & w_upper_nxt[WIDTH];

   mult_addsub_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_upper       (r_acc[AW-1:WIDTH]),
      .i_m           (r_m),
      .i_signed_mode (r_signed),
      .i_last_iter   (w_last_iter),
      .i_lsb         (r_acc[0]),
      .o_upper_nxt   (w_upper_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_signed    <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_m        <= m;
                  r_signed   <= signed_mode;
                  r_acc      <= {{(WIDTH + 1){1'b0}}, q};
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == CNT_W'(WIDTH)) begin
                  // All iterations done: freeze the product for the consumer.
                  r_p         <= r_acc[2*WIDTH-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_acc <= {w_shift_in, w_upper_nxt, r_acc[WIDTH-1:1]};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign p         = r_p;
   assign busy      = r_busy;

endmodule
